dram_cmd_sched: RTL
===================

Name: dram_cmd_sched

Overview:
- Consumes memory requests leaving the request queue, one at a time.
- Decodes each address into bank group, bank, row and column.
- Tracks the open row of every bank and issues the DDR4 command sequence (PRE/ACT/RD/WR) under tRP, tRCD, tRAS, CL, CWL and burst timing.
- Sits between the request queue output and the DIMM model or command trace.

Parameters:
- BG_NUM, 4, bank groups
- BANK_NUM, 4, banks per group
- T_RCD, 24, ACT to RD/WR, in DIMM cycles
- T_RP, 24, PRE to ACT, in DIMM cycles
- T_RAS, 52, ACT to PRE on the same bank, in DIMM cycles
- T_CL, 24, RD to data, in DIMM cycles
- T_CWL, 20, WR to data, in DIMM cycles
- T_BURST, 4, data burst length, in DIMM cycles

Ports:
- CPU_clock  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- req_in  in  parser_out_struct  request (opcode, address, CPU_clock_count, life)
- req_valid  in  1  req_in valid
- req_ready  out  1  scheduler can accept a request
- cmd_valid  out  1  command strobe, one CPU clock wide
- cmd_code  out  dram_cmd_e  NOP/ACT/PRE/RD/WR
- cmd_bg  out  2  bank group of command
- cmd_bank  out  2  bank of command
- cmd_row  out  ROW_W  row (ACT only, else 0)
- cmd_col  out  COL_W  column (RD/WR only, else 0)
- resp_done  out  1  one-clock pulse at end of data burst
- busy  out  1  request in progress

Behaviour:
- Reset: asynchronous and active-low. While rst_n is low: state=IDLE, tick_phase=0, all counters 0, all banks closed. cmd_valid=0, cmd_code=NOP, cmd_bg/bank/row/col=0, resp_done=0, busy=0, req_ready=1.
- DIMM cycle: tick_phase toggles every CPU clock. A DIMM tick is a CPU clock edge with tick_phase==1.
  - Commands issue only on ticks.
  - Timing counters decrement only on ticks and saturate at 0.
- Handshake: transfer occurs when req_valid && req_ready at a CPU clock edge. req_ready = (state==IDLE).
  - The accepted request is latched and decoded with the package masks/offsets.
  - Requests presented while busy are not accepted; the upstream holds them.
- Opcode handling: data read and instruction fetch → RD; data write → WR.
- Per-bank state, 16 entries: open flag, open row, tRAS down-counter (loaded with T_RAS on ACT).
- FSM states: IDLE, CHECK, PRE, WAIT_RP, ACT, WAIT_RCD, COLCMD, WAIT_DATA, DONE.
  - IDLE → CHECK on accept.
  - CHECK:
    - bank open, row equal → COLCMD (hit)
    - bank closed → ACT (miss)
    - bank open, row differs → PRE (conflict)
  - PRE: wait until the bank's tRAS counter==0, then issue PRE on a tick, mark bank closed, load T_RP → WAIT_RP.
  - WAIT_RP: on counter 0 → ACT.
  - ACT: issue ACT on a tick, record row, load T_RCD and tRAS → WAIT_RCD.
  - WAIT_RCD: on counter 0 → COLCMD.
  - COLCMD: issue RD or WR on a tick, load T_CL+T_BURST (read) or T_CWL+T_BURST (write) → WAIT_DATA.
  - WAIT_DATA: on counter 0 → DONE.
  - DONE: pulse resp_done one CPU clock → IDLE.
- Counter semantics: a counter loaded at tick k reaches 0 at tick k+N; the next command issues on that same tick.
- tRAS counters of all banks run every tick regardless of FSM state.
- cmd_valid/cmd_* are registered and valid for exactly one CPU clock; they return to NOP/0 otherwise.
- Reset mid-operation: in-flight request is dropped, open-row table is cleared, no resp_done is produced.

Optional Feature:
- Macro: CLOSED_PAGE_EN.
- Defined: after each RD/WR, the FSM enters an extra state AUTOPRE. It waits for tRAS==0 and burst completion, issues PRE to the same bank, then waits T_RP before DONE. Every request therefore sees a closed bank (ACT, no PRE before it).
- Undefined: open-page policy exactly as above; AUTOPRE state absent.

Decomposition:
- global_defs package:
  - dram_cmd_e enum
  - ROW_W, COL_W
  - T_* defaults
- Existing in global_defs, reused: address masks/offsets and parser_out_struct.
- One sub-module: dram_bank_table. Holds the 16-entry open flag/row/tRAS counter array, with lookup ports (hit, open) and update ports (act, pre, tick).

Test Plan:
- Read, bank group 1 bank 2 row 0x5 col 0x10, all banks closed → ACT(bg1,b2,row5); RD 24 ticks (48 CPU clocks) later; resp_done 28 ticks after RD; no PRE.
- Second read to the same row, issued after done → RD on first tick after CHECK; no ACT/PRE; resp_done 28 ticks after RD.
- Read to bg1 b2 row 0x6 immediately after the first completes → PRE no earlier than 52 ticks after the original ACT; ACT 24 ticks after PRE; RD 24 ticks after ACT.
- Write to a closed bank → ACT; WR 24 ticks later; resp_done 24 ticks after WR. Instruction fetch to the same row → RD only.
- req_valid held high while busy → req_ready=0, no second accept until DONE. Assert rst_n low during WAIT_RCD → all outputs reset immediately, no resp_done; next request to the same bank issues ACT.
- CLOSED_PAGE_EN defined, two reads to the same row → each produces ACT, RD, PRE; the second ACT is no earlier than T_RP after the first PRE.

Source files
------------

// File: rtl/global_defs_pkg.sv
// -----------------------------------------------------------------------------
// global_defs: shared definitions for the memory request path.
//   - opcode_e / parser_out_struct : request format leaving the request queue
//   - address masks/offsets and decode helpers (col | bank | bg | row)
//   - dram_cmd_e                   : DDR4 command codes driven to the DIMM model
//   - ROW_W, COL_W and default DDR4 timing values (in DIMM cycles)
// Optional build macro used by the scheduler: CLOSED_PAGE_EN.
// -----------------------------------------------------------------------------
package global_defs;

    localparam int ADDR_W = 32;
    localparam int ROW_W  = 16;
    localparam int COL_W  = 10;
    localparam int BG_W   = 2;
    localparam int BANK_W = 2;

    // Address map, low to high: column, bank, bank group, row.
    localparam int COL_OFFSET  = 0;
    localparam int BANK_OFFSET = 10;
    localparam int BG_OFFSET   = 12;
    localparam int ROW_OFFSET  = 14;

    localparam logic [ADDR_W-1:0] COL_MASK  = 32'h0000_03FF;
    localparam logic [ADDR_W-1:0] BANK_MASK = 32'h0000_0003;
    localparam logic [ADDR_W-1:0] BG_MASK   = 32'h0000_0003;
    localparam logic [ADDR_W-1:0] ROW_MASK  = 32'h0000_FFFF;

    // Default geometry and timing (DIMM cycles).
    localparam int BG_NUM_DEF   = 4;
    localparam int BANK_NUM_DEF = 4;
    localparam int T_RCD_DEF    = 24;
    localparam int T_RP_DEF     = 24;
    localparam int T_RAS_DEF    = 52;
    localparam int T_CL_DEF     = 24;
    localparam int T_CWL_DEF    = 20;
    localparam int T_BURST_DEF  = 4;

    typedef enum logic [1:0] {
        OP_DATA_READ   = 2'd0,
        OP_DATA_WRITE  = 2'd1,
        OP_INSTR_FETCH = 2'd2,
        OP_RSVD        = 2'd3
    } opcode_e;

    typedef struct packed {
        opcode_e           opcode;
        logic [ADDR_W-1:0] address;
        logic [31:0]       CPU_clock_count;
        logic [7:0]        life;
    } parser_out_struct;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } dram_cmd_e;

    function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] addr);
        return COL_W'((addr >> COL_OFFSET) & COL_MASK);
    endfunction

    function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] addr);
        return BANK_W'((addr >> BANK_OFFSET) & BANK_MASK);
    endfunction

    function automatic logic [BG_W-1:0] addr_bg(input logic [ADDR_W-1:0] addr);
        return BG_W'((addr >> BG_OFFSET) & BG_MASK);
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] addr);
        return ROW_W'((addr >> ROW_OFFSET) & ROW_MASK);
    endfunction

endpackage

// File: rtl/dram_bank_table.sv
// -----------------------------------------------------------------------------
// dram_bank_table: per-bank open-row bookkeeping for dram_cmd_sched.
// Each entry holds an open flag, the open row and a tRAS down-counter.
//   CPU_clock, rst_n : clock, asynchronous active-low reset (clears all entries)
//   tick             : DIMM tick qualifier; tRAS counters decrement only on ticks
//   idx              : bank index shared by lookup and update (the scheduler only
//                      ever touches the bank of its single in-flight request)
//   lookup_row       : row compared against the open row of bank idx
//   lookup_open      : bank idx is open
//   lookup_hit       : bank idx is open on lookup_row
//   lookup_ras_done  : bank idx tRAS counter is 0 after the current tick
//   act_en, act_row  : ACT issued to bank idx (open, record row, load tRAS)
//   pre_en           : PRE issued to bank idx (close)
// -----------------------------------------------------------------------------
module dram_bank_table
    import global_defs::*;
#(
    parameter int NUM_BANKS = 16,
    parameter int T_RAS     = T_RAS_DEF,
    parameter int IDX_W     = $clog2(NUM_BANKS)
)(
    input  logic             CPU_clock,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [IDX_W-1:0] idx,
    input  logic [ROW_W-1:0] lookup_row,
    output logic             lookup_open,
    output logic             lookup_hit,
    output logic             lookup_ras_done,
    input  logic             act_en,
    input  logic [ROW_W-1:0] act_row,
    input  logic             pre_en
);
    localparam int RAS_W = $clog2(T_RAS + 1);

    logic [NUM_BANKS-1:0]            open_q;
    logic [NUM_BANKS-1:0][ROW_W-1:0] row_q;
    logic [NUM_BANKS-1:0][RAS_W-1:0] ras_q;

    always_ff @(posedge CPU_clock or negedge rst_n) begin
        if (!rst_n) begin
            open_q <= '0;
            row_q  <= '0;
            ras_q  <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (act_en && (idx == IDX_W'(b))) begin
                    open_q[b] <= 1'b1;
                    row_q[b]  <= act_row;
                    ras_q[b]  <= RAS_W'(T_RAS);
                end else begin
                    if (pre_en && (idx == IDX_W'(b)))
                        open_q[b] <= 1'b0;
                    // Every bank's tRAS window keeps running, whatever the
                    // scheduler is doing.
                    if (tick && (ras_q[b] != '0))
                        ras_q[b] <= ras_q[b] - 1'b1;
                end
            end
        end
    end

    assign lookup_open     = open_q[idx];
    assign lookup_hit      = open_q[idx] && (row_q[idx] == lookup_row);
    // A count of 1 reaches 0 on the current tick, so a PRE may go out on it.
    assign lookup_ras_done = (ras_q[idx] <= RAS_W'(1));

endmodule

// File: rtl/dram_cmd_sched.sv
// -----------------------------------------------------------------------------
// dram_cmd_sched: single-request DDR4 command scheduler.
// Takes one request at a time from the request queue, decodes bank group /
// bank / row / column, and issues PRE/ACT/RD/WR on DIMM ticks (every second
// CPU clock) honouring tRP, tRCD, tRAS, CL/CWL and burst length.
//   CPU_clock, rst_n   : clock, asynchronous active-low reset
//   req_in, req_valid  : incoming request and its valid
//   req_ready          : scheduler idle, request will be accepted
//   cmd_valid          : one-CPU-clock command strobe
//   cmd_code/bg/bank   : command and target bank
//   cmd_row / cmd_col  : row on ACT, column on RD/WR, otherwise 0
//   resp_done          : one-clock pulse when the data burst completes
//   busy               : a request is in progress
// Build macro CLOSED_PAGE_EN: precharge the bank after every access
// (closed-page policy); undefined gives an open-page policy.
// -----------------------------------------------------------------------------
module dram_cmd_sched
    import global_defs::*;
#(
    parameter int BG_NUM   = BG_NUM_DEF,
    parameter int BANK_NUM = BANK_NUM_DEF,
    parameter int T_RCD    = T_RCD_DEF,
    parameter int T_RP     = T_RP_DEF,
    parameter int T_RAS    = T_RAS_DEF,
    parameter int T_CL     = T_CL_DEF,
    parameter int T_CWL    = T_CWL_DEF,
    parameter int T_BURST  = T_BURST_DEF
)(
    input  logic             CPU_clock,
    input  logic             rst_n,
    input  parser_out_struct req_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             cmd_valid,
    output dram_cmd_e        cmd_code,
    output logic [1:0]       cmd_bg,
    output logic [1:0]       cmd_bank,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    output logic             resp_done,
    output logic             busy
);
    localparam int NUM_BANKS = BG_NUM * BANK_NUM;
    localparam int IDX_W     = $clog2(NUM_BANKS);
    localparam int RD_LAT    = T_CL + T_BURST;
    localparam int WR_LAT    = T_CWL + T_BURST;
    localparam int MAX_A     = (T_RP > T_RCD) ? T_RP : T_RCD;
    localparam int MAX_B     = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_MAX   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PRE,
        ST_WAIT_RP,
        ST_ACT,
        ST_WAIT_RCD,
        ST_COLCMD,
        ST_WAIT_DATA,
        ST_DONE
`ifdef CLOSED_PAGE_EN
        , ST_AUTOPRE
`endif
    } sched_state_e;

    sched_state_e     state;
    logic             tick_phase;
    logic [CNT_W-1:0] cnt;

    logic             req_write;
    logic [BG_W-1:0]  req_bg;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0] req_row;
    logic [COL_W-1:0] req_col;
    logic [IDX_W-1:0] bank_idx;

    logic             bt_open;
    logic             bt_hit;
    logic             bt_ras_done;
    logic             act_fire;
    logic             pre_fire;
    logic             autopre_fire;
    logic             cnt_last;

    // Timestamp and life travel with the request but play no part in timing.
    logic             unused_req_bits;
    assign unused_req_bits = ^req_in;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign bank_idx  = IDX_W'(req_bg) * IDX_W'(BANK_NUM) + IDX_W'(req_bank);

    // Loads happen on ticks, so the wait states see the count on the off-tick
    // edge in between. A count of 1 there hits 0 on the next tick, which is
    // exactly when the following command must go out.
    assign cnt_last = !tick_phase && (cnt <= CNT_W'(1));

    assign act_fire = tick_phase && (state == ST_ACT);

`ifdef CLOSED_PAGE_EN
    logic pre_sent;
    // Auto-precharge waits for both the burst (cnt) and tRAS to run out.
    assign autopre_fire = tick_phase && (state == ST_AUTOPRE) && !pre_sent &&
                          (cnt <= CNT_W'(1)) && bt_ras_done;
`else
    assign autopre_fire = 1'b0;
`endif

    assign pre_fire = (tick_phase && (state == ST_PRE) && bt_ras_done) || autopre_fire;

    dram_bank_table #(
        .NUM_BANKS (NUM_BANKS),
        .T_RAS     (T_RAS),
        .IDX_W     (IDX_W)
    ) u_bank_table (
        .CPU_clock       (CPU_clock),
        .rst_n           (rst_n),
        .tick            (tick_phase),
        .idx             (bank_idx),
        .lookup_row      (req_row),
        .lookup_open     (bt_open),
        .lookup_hit      (bt_hit),
        .lookup_ras_done (bt_ras_done),
        .act_en          (act_fire),
        .act_row         (req_row),
        .pre_en          (pre_fire)
    );

    always_ff @(posedge CPU_clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tick_phase <= 1'b0;
            cnt        <= '0;
            req_write  <= 1'b0;
            req_bg     <= '0;
            req_bank   <= '0;
            req_row    <= '0;
            req_col    <= '0;
            cmd_valid  <= 1'b0;
            cmd_code   <= CMD_NOP;
            cmd_bg     <= '0;
            cmd_bank   <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            resp_done  <= 1'b0;
`ifdef CLOSED_PAGE_EN
            pre_sent   <= 1'b0;
`endif
        end else begin
            tick_phase <= ~tick_phase;

            // Command bus and response are single-clock strobes.
            cmd_valid <= 1'b0;
            cmd_code  <= CMD_NOP;
            cmd_bg    <= '0;
            cmd_bank  <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            resp_done <= 1'b0;

            if (tick_phase && (cnt != '0))
                cnt <= cnt - 1'b1;

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Data read, instruction fetch and the reserved code
                        // all take the read path.
                        req_write <= (req_in.opcode == OP_DATA_WRITE);
                        req_bg    <= addr_bg(req_in.address);
                        req_bank  <= addr_bank(req_in.address);
                        req_row   <= addr_row(req_in.address);
                        req_col   <= addr_col(req_in.address);
                        state     <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (bt_hit)       state <= ST_COLCMD;
                    else if (bt_open) state <= ST_PRE;
                    else              state <= ST_ACT;
                end

                ST_PRE: begin
                    if (pre_fire) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= CMD_PRE;
                        cmd_bg    <= req_bg;
                        cmd_bank  <= req_bank;
                        cnt       <= CNT_W'(T_RP);
                        state     <= ST_WAIT_RP;
                    end
                end

                ST_WAIT_RP: begin
                    if (cnt_last) state <= ST_ACT;
                end

                ST_ACT: begin
                    if (act_fire) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= CMD_ACT;
                        cmd_bg    <= req_bg;
                        cmd_bank  <= req_bank;
                        cmd_row   <= req_row;
                        cnt       <= CNT_W'(T_RCD);
                        state     <= ST_WAIT_RCD;
                    end
                end

                ST_WAIT_RCD: begin
                    if (cnt_last) state <= ST_COLCMD;
                end

                ST_COLCMD: begin
                    if (tick_phase) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= req_write ? CMD_WR : CMD_RD;
                        cmd_bg    <= req_bg;
                        cmd_bank  <= req_bank;
                        cmd_col   <= req_col;
                        cnt       <= req_write ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
`ifdef CLOSED_PAGE_EN
                        pre_sent  <= 1'b0;
                        state     <= ST_AUTOPRE;
`else
                        state     <= ST_WAIT_DATA;
`endif
                    end
                end

                ST_WAIT_DATA: begin
                    if (cnt_last) state <= ST_DONE;
                end

`ifdef CLOSED_PAGE_EN
                ST_AUTOPRE: begin
                    // Two phases: issue the precharge, then sit out tRP.
                    if (autopre_fire) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= CMD_PRE;
                        cmd_bg    <= req_bg;
                        cmd_bank  <= req_bank;
                        cnt       <= CNT_W'(T_RP);
                        pre_sent  <= 1'b1;
                    end else if (pre_sent && cnt_last) begin
                        state     <= ST_DONE;
                    end
                end
`endif

                ST_DONE: begin
                    resp_done <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
